au_op_sequencer: RTL
====================

AU_OP_SEQUENCER -- requirements
Module: au_op_sequencer

Interface
REQ-001 SHALL have parameters: W, default 24, datapath width; AW, default 5, Data Bank address width; TMO, default 255, AU-wait watchdog limit in cycles.
REQ-002 SHALL have ports: clk  in  1  clock, all state changes on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: cmd_valid in 1, cmd_ready out 1, cmd_op in 4, cmd_ra in AW, cmd_rb in AW, cmd_wa in AW, cmd_tr in 1 (R from RQ), cmd_ts in 1 (S from RD), cmd_dst in 2 (00 bank, 01 RQ, 10 RD, 11 bank+RQ).
REQ-005 SHALL have ports: bank_re out 1, bank_ra out AW, bank_rb out AW, bank_we out 1, bank_wa out AW, bank_wd out W.
REQ-006 SHALL have ports: sel_R out 2, sel_S out 2, inv_R out 1, inv_S out 1, sel_I out 2 (Router B controls).
REQ-007 SHALL have ports: au_start out 1, au_mode out 2 (00 add, 01 mul, 10 div), au_done in 1, au_res in W.
REQ-008 SHALL have ports: rq_we out 1, rd_we out 1, busy out 1, op_done out 1 (pulse), err out 1 (pulse).

Function
REQ-009 SHALL implement FSM IDLE -> READ -> ISSUE -> WAIT -> WRITE -> IDLE.
REQ-010 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on cmd_valid&&cmd_ready and latched in full.
REQ-011 READ SHALL assert bank_re for one cycle with the latched ra/rb; data is valid in ISSUE (1-cycle synchronous read).
REQ-012 ISSUE SHALL assert au_start for exactly one cycle.
REQ-013 Router fields SHALL be driven from ISSUE through WAIT, held stable until au_done; they SHALL be 0 in all other states.
REQ-014 Opcode decode (sel_R/sel_S: 00 A|B, 01 RQ|RD, 10 zero, 11 ones; sel_I: 00 zero, 01 +1, 10 -1): 0 ADD R+S; 1 SUB inv_S=1, sel_I=01; 2 NEG R=zero, inv_S=1, sel_I=01 on S; 3 MOV S=zero; 4 INC S=zero, sel_I=01; 5 DEC S=zero, sel_I=10; 6 MUL au_mode=01; 7 DIV au_mode=10. Opcodes 0-5 SHALL use au_mode=00.
REQ-015 cmd_tr=1 SHALL replace sel_R 00 with 01; cmd_ts=1 SHALL replace sel_S 00 with 01; zero/ones selections are unaffected.
REQ-016 Opcodes 8-15 SHALL be illegal: accepted, err pulses the cycle after acceptance, FSM returns to IDLE, no bank/AU/temp-register activity.
REQ-017 WAIT SHALL exit to WRITE the cycle after au_done=1; au_res SHALL be captured on that au_done cycle.
REQ-018 The watchdog SHALL count WAIT cycles from 0; on reaching TMO without au_done it SHALL pulse err, return to IDLE and skip WRITE.
REQ-019 WRITE (one cycle) SHALL assert bank_we with bank_wa=latched wa and bank_wd=captured result for cmd_dst 00/11, rq_we for 01/11, rd_we for 10; op_done SHALL pulse in the same cycle.
REQ-020 au_done outside WAIT SHALL be ignored.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Best-case latency SHALL be 5 cycles from acceptance to op_done, au_done arriving one cycle after au_start.

Reset
REQ-023 rst SHALL force IDLE immediately, including mid-operation; all outputs SHALL be 0 except cmd_ready=1; the watchdog and latched command SHALL clear.
REQ-024 The first command SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-025 A shared package SHALL hold opcode constants, the sel_R/sel_S/sel_I encodings, au_mode encodings, the cmd_dst encodings and the FSM state typedef.
REQ-026 Opcode-to-router decode SHALL be a combinational sub-module au_op_decode (op, tr, ts -> sel_R, sel_S, inv_R, inv_S, sel_I, au_mode, illegal).

Verification
REQ-027 SUB ra=3, rb=4, wa=9, dst=00, au_done 1 cycle after au_start -> sel_S=00, inv_S=1, sel_I=01; bank_we with wa=9 and au_res exactly 5 cycles after acceptance.
REQ-028 INC with tr=1, dst=01 -> sel_R=01, sel_S=10, sel_I=01; rq_we pulses, bank_we stays 0.
REQ-029 MUL with au_done withheld -> au_mode=01 held; err pulses after TMO=255 WAIT cycles; no writes; cmd_ready returns to 1.
REQ-030 Illegal op=12 -> err pulse the next cycle; bank_re, au_start and all write enables stay 0.
REQ-031 rst asserted during WAIT of DIV -> outputs zero and cmd_ready=1 asynchronously; a following ADD completes normally.
REQ-032 Spurious au_done in IDLE and READ, plus back-to-back commands with cmd_valid held -> no extra writes; second command accepted only after op_done.

Source files
------------

// File: rtl/au_op_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// au_op_sequencer_pkg
// Shared definitions for the arithmetic-unit operation sequencer:
//   - opcode constants (0..7 legal, 8..15 illegal)
//   - Router B operand selects (sel_R / sel_S) and increment selects (sel_I)
//   - AU mode encodings and result destination (cmd_dst) encodings
//   - FSM state type
// ---------------------------------------------------------------------------
package au_op_sequencer_pkg;

  // Opcodes
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_NEG = 4'd2;
  localparam logic [3:0] OP_MOV = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_DEC = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd6;
  localparam logic [3:0] OP_DIV = 4'd7;

  // Operand selects for R and S
  localparam logic [1:0] SEL_AB   = 2'b00;  // bank port A (R) / port B (S)
  localparam logic [1:0] SEL_QD   = 2'b01;  // RQ (R) / RD (S) temp registers
  localparam logic [1:0] SEL_ZERO = 2'b10;
  localparam logic [1:0] SEL_ONES = 2'b11;

  // Increment-in selects
  localparam logic [1:0] INC_ZERO   = 2'b00;
  localparam logic [1:0] INC_PLUS1  = 2'b01;
  localparam logic [1:0] INC_MINUS1 = 2'b10;

  // AU modes
  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_MUL = 2'b01;
  localparam logic [1:0] MODE_DIV = 2'b10;

  // Result destinations
  localparam logic [1:0] DST_BANK = 2'b00;
  localparam logic [1:0] DST_RQ   = 2'b01;
  localparam logic [1:0] DST_RD   = 2'b10;
  localparam logic [1:0] DST_BOTH = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE
  } state_t;

  // True when the destination includes the Data Bank.
  function automatic logic dst_to_bank(input logic [1:0] dst);
    return (dst == DST_BANK) || (dst == DST_BOTH);
  endfunction

  // True when the destination includes the RQ temp register.
  function automatic logic dst_to_rq(input logic [1:0] dst);
    return (dst == DST_RQ) || (dst == DST_BOTH);
  endfunction

endpackage

// File: rtl/au_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// au_op_sequencer_if
// Bundles every non-clock/reset signal of the sequencer.
//   cmd_*   : command handshake from the host (valid/ready)
//   bank_*  : Data Bank read/write controls
//   sel_*, inv_* : Router B controls
//   au_*    : arithmetic unit start/mode/done/result
//   rq_we, rd_we, busy, op_done, err : status and temp-register writes
// Modports: slave = the sequencer, master = the host/environment side.
// ---------------------------------------------------------------------------
interface au_op_sequencer_if #(
  parameter int W  = 24,
  parameter int AW = 5
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_ra;
  logic [AW-1:0] cmd_rb;
  logic [AW-1:0] cmd_wa;
  logic          cmd_tr;
  logic          cmd_ts;
  logic [1:0]    cmd_dst;

  logic          bank_re;
  logic [AW-1:0] bank_ra;
  logic [AW-1:0] bank_rb;
  logic          bank_we;
  logic [AW-1:0] bank_wa;
  logic [W-1:0]  bank_wd;

  logic [1:0]    sel_R;
  logic [1:0]    sel_S;
  logic          inv_R;
  logic          inv_S;
  logic [1:0]    sel_I;

  logic          au_start;
  logic [1:0]    au_mode;
  logic          au_done;
  logic [W-1:0]  au_res;

  logic          rq_we;
  logic          rd_we;
  logic          busy;
  logic          op_done;
  logic          err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_wa, cmd_tr, cmd_ts, cmd_dst,
    input  au_done, au_res,
    output cmd_ready,
    output bank_re, bank_ra, bank_rb, bank_we, bank_wa, bank_wd,
    output sel_R, sel_S, inv_R, inv_S, sel_I,
    output au_start, au_mode,
    output rq_we, rd_we, busy, op_done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_wa, cmd_tr, cmd_ts, cmd_dst,
    output au_done, au_res,
    input  cmd_ready,
    input  bank_re, bank_ra, bank_rb, bank_we, bank_wa, bank_wd,
    input  sel_R, sel_S, inv_R, inv_S, sel_I,
    input  au_start, au_mode,
    input  rq_we, rd_we, busy, op_done, err
  );
endinterface

// File: rtl/au_op_sequencer_decode.sv
// ---------------------------------------------------------------------------
// au_op_decode
// Combinational opcode-to-router decode.
//   in : op (4b), tr (R from RQ), ts (S from RD)
//   out: sel_R, sel_S, inv_R, inv_S, sel_I, au_mode, illegal
// Illegal opcodes return all-zero controls with illegal=1.
// ---------------------------------------------------------------------------
module au_op_decode
  import au_op_sequencer_pkg::*;
(
  input  logic [3:0] op,
  input  logic       tr,
  input  logic       ts,
  output logic [1:0] sel_R,
  output logic [1:0] sel_S,
  output logic       inv_R,
  output logic       inv_S,
  output logic [1:0] sel_I,
  output logic [1:0] au_mode,
  output logic       illegal
);

  always_comb begin
    sel_R   = SEL_AB;
    sel_S   = SEL_AB;
    inv_R   = 1'b0;
    inv_S   = 1'b0;
    sel_I   = INC_ZERO;
    au_mode = MODE_ADD;
    illegal = 1'b0;

    case (op)
      OP_ADD: begin
        sel_R = SEL_AB;
      end
      OP_SUB: begin            // R + ~S + 1
        inv_S = 1'b1;
        sel_I = INC_PLUS1;
      end
      OP_NEG: begin            // 0 + ~S + 1
        sel_R = SEL_ZERO;
        inv_S = 1'b1;
        sel_I = INC_PLUS1;
      end
      OP_MOV: begin
        sel_S = SEL_ZERO;
      end
      OP_INC: begin
        sel_S = SEL_ZERO;
        sel_I = INC_PLUS1;
      end
      OP_DEC: begin
        sel_S = SEL_ZERO;
        sel_I = INC_MINUS1;
      end
      OP_MUL: begin
        au_mode = MODE_MUL;
      end
      OP_DIV: begin
        au_mode = MODE_DIV;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase

    // Temp-register overrides only redirect bank operands; constant
    // selections (zero/ones) are kept as decoded.
    if (!illegal && tr && (sel_R == SEL_AB)) sel_R = SEL_QD;
    if (!illegal && ts && (sel_S == SEL_AB)) sel_S = SEL_QD;
  end

endmodule

// File: rtl/au_op_sequencer.sv
// ---------------------------------------------------------------------------
// au_op_sequencer
// Sequences one arithmetic operation per accepted command:
//   IDLE -> READ (bank read) -> ISSUE (au_start) -> WAIT (au_done or
//   watchdog) -> WRITE (result to bank / RQ / RD) -> IDLE.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : au_op_sequencer_if.slave (command, bank, router, AU, status)
// Parameters: W datapath width, AW bank address width, TMO watchdog limit
// (number of WAIT cycles tolerated without au_done, must be >= 1).
// ---------------------------------------------------------------------------
module au_op_sequencer
  import au_op_sequencer_pkg::*;
#(
  parameter int W   = 24,
  parameter int AW  = 5,
  parameter int TMO = 255
) (
  input  logic              clk,
  input  logic              rst,
  au_op_sequencer_if.slave  bus
);

  localparam int WDW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [WDW-1:0] TMO_LAST = WDW'(TMO - 1);

  state_t         state_reg, state_next;
  logic [WDW-1:0] wdog_reg, wdog_next;
  logic           err_reg, err_next;

  // Latched command and captured result
  logic [3:0]     op_reg;
  logic [AW-1:0]  ra_reg, rb_reg, wa_reg;
  logic           tr_reg, ts_reg;
  logic [1:0]     dst_reg;
  logic [W-1:0]   res_reg;

  logic           accept;
  logic           route_en;

  // Decode sees the live command while idle (for the illegal check at
  // acceptance) and the latched command afterwards.
  logic [3:0]     dec_op;
  logic           dec_tr, dec_ts;
  logic [1:0]     d_sel_R, d_sel_S, d_sel_I, d_mode;
  logic           d_inv_R, d_inv_S, d_illegal;

  assign accept = (state_reg == ST_IDLE) && bus.cmd_valid;
  assign dec_op = (state_reg == ST_IDLE) ? bus.cmd_op : op_reg;
  assign dec_tr = (state_reg == ST_IDLE) ? bus.cmd_tr : tr_reg;
  assign dec_ts = (state_reg == ST_IDLE) ? bus.cmd_ts : ts_reg;

  au_op_decode u_decode (
    .op      (dec_op),
    .tr      (dec_tr),
    .ts      (dec_ts),
    .sel_R   (d_sel_R),
    .sel_S   (d_sel_S),
    .inv_R   (d_inv_R),
    .inv_S   (d_inv_S),
    .sel_I   (d_sel_I),
    .au_mode (d_mode),
    .illegal (d_illegal)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and outputs
  always_comb begin
    state_next    = state_reg;
    wdog_next     = wdog_reg;
    err_next      = 1'b0;
    route_en      = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.bank_re   = 1'b0;
    bus.bank_ra   = '0;
    bus.bank_rb   = '0;
    bus.bank_we   = 1'b0;
    bus.bank_wa   = '0;
    bus.bank_wd   = '0;
    bus.au_start  = 1'b0;
    bus.rq_we     = 1'b0;
    bus.rd_we     = 1'b0;
    bus.op_done   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (accept) begin
          // Illegal commands are consumed here and only raise err.
          if (d_illegal) err_next = 1'b1;
          else           state_next = ST_READ;
        end
      end
      ST_READ: begin
        bus.bank_re = 1'b1;
        bus.bank_ra = ra_reg;
        bus.bank_rb = rb_reg;
        state_next  = ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.au_start = 1'b1;
        route_en     = 1'b1;
        wdog_next    = '0;
        state_next   = ST_WAIT;
      end
      ST_WAIT: begin
        route_en = 1'b1;
        if (bus.au_done) begin
          state_next = ST_WRITE;
        end else if (wdog_reg == TMO_LAST) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          wdog_next = wdog_reg + 1'b1;
        end
      end
      ST_WRITE: begin
        bus.op_done = 1'b1;
        bus.rq_we   = dst_to_rq(dst_reg);
        bus.rd_we   = (dst_reg == DST_RD);
        if (dst_to_bank(dst_reg)) begin
          bus.bank_we = 1'b1;
          bus.bank_wa = wa_reg;
          bus.bank_wd = res_reg;
        end
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.sel_R   = route_en ? d_sel_R : 2'b00;
  assign bus.sel_S   = route_en ? d_sel_S : 2'b00;
  assign bus.inv_R   = route_en & d_inv_R;
  assign bus.inv_S   = route_en & d_inv_S;
  assign bus.sel_I   = route_en ? d_sel_I : 2'b00;
  assign bus.au_mode = route_en ? d_mode  : 2'b00;
  assign bus.busy    = (state_reg != ST_IDLE);
  assign bus.err     = err_reg;

  // Command latch, result capture, watchdog and err pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_reg <= '0;
      err_reg  <= 1'b0;
      op_reg   <= '0;
      ra_reg   <= '0;
      rb_reg   <= '0;
      wa_reg   <= '0;
      tr_reg   <= 1'b0;
      ts_reg   <= 1'b0;
      dst_reg  <= '0;
      res_reg  <= '0;
    end else begin
      wdog_reg <= wdog_next;
      err_reg  <= err_next;
      if (accept) begin
        op_reg  <= bus.cmd_op;
        ra_reg  <= bus.cmd_ra;
        rb_reg  <= bus.cmd_rb;
        wa_reg  <= bus.cmd_wa;
        tr_reg  <= bus.cmd_tr;
        ts_reg  <= bus.cmd_ts;
        dst_reg <= bus.cmd_dst;
      end
      if ((state_reg == ST_WAIT) && bus.au_done) begin
        res_reg <= bus.au_res;
      end
    end
  end

endmodule
